// File: rtl/time_tag_capture_if.sv
// Tag stream from time_tag_capture toward the register bank.
// Handshake: an entry moves when tag_valid && tag_ready at a rising clk edge; tag_data holds while tag_valid && !tag_ready.
interface time_tag_capture_if #(
    parameter int CW = 27,
    parameter int SW = 4
);
    logic [CW+SW-1:0] tag_data;
    logic             tag_valid;
    logic             tag_ready;

    modport master (
        output tag_data,
        output tag_valid,
        input  tag_ready
    );

    modport slave (
        input  tag_data,
        input  tag_valid,
        output tag_ready
    );
endinterface

// File: rtl/time_tag_capture.sv
// Trigger/PPS capture of the free-running cycle count with a first-word-fall-through tag FIFO.
// Optional macro TIME_TAG_DROP_CNT_EN adds the saturating drop_cnt output.
module time_tag_capture #(
    parameter int CW    = 27,
    parameter int SW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [CW-1:0]            count,
    input  logic                     pps,
    input  logic                     trig,
    output logic [CW-1:0]            pps_count,
    output logic                     pps_lock,
    output logic [SW-1:0]            sec,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    input  logic                     ovf_clr,
`ifdef TIME_TAG_DROP_CNT_EN
    output logic [7:0]               drop_cnt,
`endif
    time_tag_capture_if.master       tag_if
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        PPS_NONE = 2'd0,
        PPS_ONE  = 2'd1,
        PPS_LOCK = 2'd2
    } pps_state_t;

    pps_state_t       pps_state;
    pps_state_t       pps_state_nxt;

    logic [CW+SW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign pop   = !empty && tag_if.tag_ready;
    // A full FIFO still accepts a trigger when the head leaves in the same cycle.
    assign push  = trig && (!full || pop);
    assign drop  = trig && full && !pop;

    // PPS sample and seconds index; sec is read pre-increment by a coincident trigger.
    always_ff @(posedge clk) begin
        if (!res) begin
            pps_count <= '0;
            sec       <= '0;
        end else if (pps) begin
            pps_count <= count;
            sec       <= sec + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            pps_state <= PPS_NONE;
        end else begin
            pps_state <= pps_state_nxt;
        end
    end

    // The first PPS after reset closes a partial interval, so lock needs two.
    always_comb begin
        pps_state_nxt = pps_state;
        case (pps_state)
            PPS_NONE: if (pps) pps_state_nxt = PPS_ONE;
            PPS_ONE:  if (pps) pps_state_nxt = PPS_LOCK;
            PPS_LOCK: pps_state_nxt = PPS_LOCK;
            default:  pps_state_nxt = PPS_NONE;
        endcase
    end

    assign pps_lock = (pps_state == PPS_LOCK);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sec, count};
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Set beats clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (!res) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef TIME_TAG_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!res) begin
            drop_cnt <= 8'd0;
        end else if (ovf_clr) begin
            drop_cnt <= {7'd0, drop};
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    assign tag_if.tag_valid = !empty;
    assign tag_if.tag_data  = empty ? '0 : mem[rd_ptr];
    assign fifo_level       = level;

endmodule

// File: tb/tb_time_tag_capture.sv
// Self-checking bench for time_tag_capture: directed scenarios plus randomized traffic against a queue model.
module tb_time_tag_capture;

    localparam int CW    = 27;
    localparam int SW    = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk     = 1'b0;
    logic          res     = 1'b0;
    logic          pps     = 1'b0;
    logic          trig    = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] count_r = '0;

    logic [CW-1:0] pps_count;
    logic          pps_lock;
    logic [SW-1:0] sec;
    logic [LW-1:0] fifo_level;
    logic          ovf;
`ifdef TIME_TAG_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    time_tag_capture_if #(.CW(CW), .SW(SW)) tag_if ();

    time_tag_capture #(.CW(CW), .SW(SW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .res        (res),
        .count      (count_r),
        .pps        (pps),
        .trig       (trig),
        .pps_count  (pps_count),
        .pps_lock   (pps_lock),
        .sec        (sec),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
`ifdef TIME_TAG_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .tag_if     (tag_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [CW+SW-1:0] exp_q[$];
    int               m_sec;
    int               m_seen;
    int               m_drop;
    logic [CW-1:0]    m_pps_count;
    logic             m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_step();
        logic [CW+SW-1:0] tag;
        bit               dropped;
        dropped = 1'b0;
        if (!res) begin
            exp_q.delete();
            m_sec       = 0;
            m_seen      = 0;
            m_drop      = 0;
            m_pps_count = '0;
            m_ovf       = 1'b0;
        end else begin
            tag = {SW'(m_sec), count_r};
            if (exp_q.size() > 0 && tag_if.tag_ready) void'(exp_q.pop_front());
            if (trig) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(tag);
                else dropped = 1'b1;
            end
            if (ovf_clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (dropped) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (pps) begin
                m_pps_count = count_r;
                m_sec       = (m_sec + 1) % (1 << SW);
                if (m_seen < 2) m_seen++;
            end
        end
    endtask

    // Drive one clock cycle; outputs are stable when this returns.
    task automatic cycle(input logic p, input logic t, input logic r, input logic c);
        pps              = p;
        trig             = t;
        tag_if.tag_ready = r;
        ovf_clr          = c;
        @(posedge clk);
        model_step();
        #1;
        count_r = pps ? CW'(1) : count_r + 1'b1;
    endtask

    task automatic test_reset();
        res = 1'b0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        res = 1'b1;
        n_checks++; if (pps_count !== '0) begin n_fail++; $display("FAIL reset_pps_count: got %0d expected 0", pps_count); end
        n_checks++; if (pps_lock !== 1'b0) begin n_fail++; $display("FAIL reset_pps_lock: got %b expected 0", pps_lock); end
        n_checks++; if (sec !== '0) begin n_fail++; $display("FAIL reset_sec: got %0d expected 0", sec); end
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tag_valid: got %b expected 0", tag_if.tag_valid); end
        n_checks++; if (tag_if.tag_data !== '0) begin n_fail++; $display("FAIL reset_tag_data: got %h expected 0", tag_if.tag_data); end
        n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d expected 0", fifo_level); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`ifdef TIME_TAG_DROP_CNT_EN
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    endtask

    task automatic test_pps_steady();
        count_r = '0;
        for (int i = 0; i < 300; i++) cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        n_checks++; if (pps_lock !== 1'b0) begin n_fail++; $display("FAIL pps1_lock: got %b expected 0", pps_lock); end
        n_checks++; if (pps_count !== CW'(300)) begin n_fail++; $display("FAIL pps1_count: got %0d expected 300", pps_count); end
        n_checks++; if (sec !== 4'd1) begin n_fail++; $display("FAIL pps1_sec: got %0d expected 1", sec); end
        for (int i = 0; i < 999; i++) cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        n_checks++; if (pps_count !== CW'(1000)) begin n_fail++; $display("FAIL pps2_count: got %0d expected 1000", pps_count); end
        n_checks++; if (pps_lock !== 1'b1) begin n_fail++; $display("FAIL pps2_lock: got %b expected 1", pps_lock); end
        n_checks++; if (sec !== 4'd2) begin n_fail++; $display("FAIL pps2_sec: got %0d expected 2", sec); end
    endtask

    task automatic test_trig_pps();
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        count_r = CW'(1000);
        cycle(1, 1, 0, 0);
        n_checks++; if (sec !== 4'd4) begin n_fail++; $display("FAIL trigpps_sec: got %0d expected 4", sec); end
        n_checks++; if (tag_if.tag_valid !== 1'b1) begin n_fail++; $display("FAIL trigpps_valid: got %b expected 1", tag_if.tag_valid); end
        n_checks++; if (tag_if.tag_data !== {4'd3, 27'd1000}) begin n_fail++; $display("FAIL trigpps_data: got %h expected %h", tag_if.tag_data, {4'd3, 27'd1000}); end
        n_checks++; if (pps_count !== CW'(1000)) begin n_fail++; $display("FAIL trigpps_pps_count: got %0d expected 1000", pps_count); end
        cycle(0, 0, 1, 0);
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL trigpps_pop: got %b expected 0", tag_if.tag_valid); end
    endtask

    task automatic test_single_trig();
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        count_r = 27'h000_0123;
        cycle(0, 1, 0, 0);
        n_checks++; if (tag_if.tag_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", tag_if.tag_valid); end
        n_checks++; if (tag_if.tag_data !== {4'd5, 27'h123}) begin n_fail++; $display("FAIL single_data: got %h expected %h", tag_if.tag_data, {4'd5, 27'h123}); end
        n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
        cycle(0, 0, 0, 0);
        n_checks++; if (tag_if.tag_data !== {4'd5, 27'h123}) begin n_fail++; $display("FAIL single_hold: got %h expected %h", tag_if.tag_data, {4'd5, 27'h123}); end
        cycle(0, 0, 1, 0);
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", tag_if.tag_valid); end
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d expected 0", fifo_level); end
        cycle(0, 0, 1, 0);
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL empty_pop_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [CW+SW-1:0] want[DEPTH];
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH) want[i] = {SW'(m_sec), count_r};
            cycle(0, 1, 0, 0);
        end
        n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
`ifdef TIME_TAG_DROP_CNT_EN
        n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
`endif
        cycle(0, 1, 0, 1);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop: got %b expected 1", ovf); end
`ifdef TIME_TAG_DROP_CNT_EN
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt_clr_vs_drop: got %0d expected 1", drop_cnt); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (tag_if.tag_data !== want[i]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, tag_if.tag_data, want[i]); end
            cycle(0, 0, 1, 0);
        end
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid: got %b expected 0", tag_if.tag_valid); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
        cycle(0, 0, 0, 1);
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
`ifdef TIME_TAG_DROP_CNT_EN
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_cnt_clr: got %0d expected 0", drop_cnt); end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [CW+SW-1:0] want[DEPTH+1];
        for (int i = 0; i < DEPTH; i++) begin
            want[i] = {SW'(m_sec), count_r};
            cycle(0, 1, 0, 0);
        end
        n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fpp_fill_level: got %0d expected 8", fifo_level); end
        want[DEPTH] = {SW'(m_sec), count_r};
        cycle(0, 1, 1, 0);
        n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fpp_level: got %0d expected 8", fifo_level); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 0", ovf); end
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++; if (tag_if.tag_data !== want[i]) begin n_fail++; $display("FAIL fpp_drain_%0d: got %h expected %h", i, tag_if.tag_data, want[i]); end
            cycle(0, 0, 1, 0);
        end
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained: got %b expected 0", tag_if.tag_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic p, t, r, c;
            p = ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 1) == 1);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 63) == 0) count_r = CW'($urandom);
            cycle(p, t, r, c);
            n_checks++; if (tag_if.tag_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, tag_if.tag_valid, exp_q.size() > 0); end
            n_checks++; if (fifo_level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, fifo_level, exp_q.size()); end
            if (exp_q.size() > 0) begin
                n_checks++; if (tag_if.tag_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", i, tag_if.tag_data, exp_q[0]); end
            end
            n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b expected %b", i, ovf, m_ovf); end
            n_checks++; if (sec !== SW'(m_sec)) begin n_fail++; $display("FAIL rnd_sec@%0d: got %0d expected %0d", i, sec, m_sec); end
            n_checks++; if (pps_count !== m_pps_count) begin n_fail++; $display("FAIL rnd_pps_count@%0d: got %0d expected %0d", i, pps_count, m_pps_count); end
            n_checks++; if (pps_lock !== (m_seen == 2)) begin n_fail++; $display("FAIL rnd_lock@%0d: got %b expected %b", i, pps_lock, m_seen == 2); end
`ifdef TIME_TAG_DROP_CNT_EN
            n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop_cnt@%0d: got %0d expected %0d", i, drop_cnt, m_drop); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        n_checks++; if (fifo_level !== 4'd5) begin n_fail++; $display("FAIL mid_pre_level: got %0d expected 5", fifo_level); end
        res = 1'b0;
        cycle(0, 0, 0, 0);
        res = 1'b1;
        n_checks++; if (tag_if.tag_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", tag_if.tag_valid); end
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
        n_checks++; if (sec !== '0) begin n_fail++; $display("FAIL mid_sec: got %0d expected 0", sec); end
        n_checks++; if (pps_lock !== 1'b0) begin n_fail++; $display("FAIL mid_lock: got %b expected 0", pps_lock); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
        count_r = 27'h0ABCDE;
        cycle(0, 1, 0, 0);
        n_checks++; if (tag_if.tag_data !== {4'd0, 27'h0ABCDE}) begin n_fail++; $display("FAIL mid_retag: got %h expected %h", tag_if.tag_data, {4'd0, 27'h0ABCDE}); end
        n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL mid_relevel: got %0d expected 1", fifo_level); end
    endtask

    initial begin
        tag_if.tag_ready = 1'b0;
        test_reset();
        test_pps_steady();
        test_trig_pps();
        test_single_trig();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_tag_capture.md
# time_tag_capture

Reader side of the time-tagging clock-cycle counter. Samples the free-running 27-bit cycle count on each trigger strobe and each PPS pulse. Trigger tags go with a seconds index into a small first-word-fall-through FIFO drained by a valid/ready handshake toward the AXI register bank. The PPS sample is held as the measured clocks-per-second for oscillator calibration.

## Interface
Parameters:
- `CW`, 27, width of `count` and of the count field of every tag.
- `SW`, 4, width of the wrapping seconds index.
- `DEPTH`, 8, FIFO entries; power of two, 2..64.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `res` in 1: synchronous, active-low reset.
- `count` in CW: running count from the cycle counter, same clock domain.
  - Reads 1 in the cycle after a PPS load.
- `pps` in 1: single-cycle PPS strobe, already synchronized.
  - The same pulse drives the counter's load.
- `trig` in 1: single-cycle event strobe.
- `pps_count` out CW: `count` sampled in the last PPS cycle.
- `pps_lock` out 1: high once `pps_count` spans a full PPS interval.
- `sec` out SW: seconds index, +1 per PPS, wraps.
- `tag_data` out CW+SW: head entry, {sec_at_trig, count_at_trig}.
- `tag_valid` out 1: FIFO not empty.
- `tag_ready` in 1: consumer pop; an entry is popped when `tag_valid && tag_ready`.
- `fifo_level` out clog2(DEPTH)+1: number of occupied entries.
- `ovf` out 1: sticky; set when a trigger is dropped.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Reset (`res`=0 at an edge) forces all outputs and state to 0: `pps_count`, `pps_lock`, `sec`, `tag_data`, `tag_valid`, `fifo_level`, `ovf`, FIFO pointers.
  - Reset mid-operation discards all stored tags.
- PPS cycle actions:
  - `pps_count`←`count`.
  - `sec`←`sec`+1 mod 2^SW.
  - PPS seen counter saturates at 2.
  - `pps_lock`=1 once the second PPS after reset is captured. The first capture measures a partial interval and leaves `pps_lock`=0.
- Trigger cycle: write {`sec`, `count`} as seen in that cycle.
  - `sec` is the pre-increment value; `count` is the pre-load value.
  - A trigger coincident with PPS therefore tags the end of the old second: count N, old `sec`.
- Push when `trig` and (not full or pop in the same cycle). Full with simultaneous pop: write is accepted and level is unchanged.
- Full without pop: trigger dropped, `ovf`←1, FIFO unchanged.
- Empty: pop is ignored (`tag_valid`=0). `fifo_level` never underflows.
- `ovf_clr` and a drop in the same cycle: `ovf` stays 1 (set wins).
- `tag_data` is don't-care while `tag_valid`=0.
  - It must hold stable while `tag_valid`=1 and `tag_ready`=0.

## Timing
- Latency from `trig` at edge t into an empty FIFO: `tag_valid`=1 and `tag_data` valid after edge t+1.
- Pop at edge t: the next entry is presented after edge t+1, with no bubble; back-to-back pops drain one per cycle.
- `pps_count`, `sec` and `pps_lock` update after the PPS edge, with 1-cycle latency.
- `fifo_level` and `ovf` are registered, and both reflect events of edge t after edge t+1.
- Throughput: one trigger accepted per cycle while not full.

## Configuration
- `TIME_TAG_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [7:0], reset 0.
  - +1 per dropped trigger, saturates at 255.
  - Cleared by `ovf_clr`. A drop in the same cycle as `ovf_clr` leaves `drop_cnt`=1.
- Undefined: no `drop_cnt` port and no counter logic; `ovf` behaviour is identical.

## Test plan
- Reset then steady state:
  - Stimulus: drive `count` from a model counter; PPS every 1000 cycles.
  - First PPS: `pps_lock`=0.
  - Second PPS: `pps_count`=1000, `pps_lock`=1, `sec`=2.
- Single trigger, check tag contents and latency:
  - Stimulus: `trig` when `count`=0x000_0123 and `sec`=5.
  - One cycle later: `tag_valid`=1, `tag_data`={5, 0x123}, `fifo_level`=1.
  - Pop with `tag_ready`=1: `tag_valid`=0 next cycle.
- Trigger coincident with PPS:
  - Stimulus: `count`=1000, `sec`=3.
  - Tag is {3, 1000}; `sec` becomes 4.
- Overflow, with `tag_ready`=0 throughout:
  - Stimulus: 8 triggers, then 2 more.
  - `fifo_level`=8, `ovf`=1, `drop_cnt`=2 (macro on).
  - Draining returns the first 8 tags in order.
  - Then `ovf_clr`: `ovf`=0, `drop_cnt`=0.
- Full with simultaneous push and pop:
  - Level stays 8, `ovf` stays 0, and the new tag is last in the drain order.
- Reset mid-stream with 5 entries stored:
  - Drive `res`=0 for 1 cycle.
  - `tag_valid`=0, `fifo_level`=0, `sec`=0, `pps_lock`=0.
